ram_fifo_ctrl: RTL and testbench
================================

RAM_FIFO_CTRL -- requirements
Module: ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter ADDR_W, default 3, meaning RAM address width; depth is 2**ADDR_W (8).
REQ-002 SHALL have parameter DATA_W, default 3, meaning RAM data width.
REQ-003 SHALL have port clk, input, 1, the single clock; it drives both RAM ports (wclk and rclk tied to clk).
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have ports req0_valid / req1_valid, input, 1 each, write request from requester 0 / 1.
REQ-006 SHALL have ports req0_data / req1_data, input, DATA_W each, write data from requester 0 / 1.
REQ-007 SHALL have ports req0_ready / req1_ready, output, 1 each, write accepted this cycle.
REQ-008 SHALL have port pop, input, 1, read request from the consumer.
REQ-009 SHALL have port rdata_valid, output, 1, RAM rdata holds the popped word this cycle.
REQ-010 SHALL have ports full / empty, output, 1 each, occupancy flags.
REQ-011 SHALL have ports ram_wen (1), ram_waddr (ADDR_W), ram_wdata (DATA_W), all outputs, to the RAM write port.
REQ-012 SHALL have ports ram_ren (1) and ram_raddr (ADDR_W), both outputs, to the RAM read port.

Function
REQ-013 SHALL keep wptr and rptr, ADDR_W+1 bits each; RAM addresses are the low ADDR_W bits; wrap from 2**(ADDR_W+1)-1 to 0.
REQ-014 SHALL assert empty when wptr==rptr, and full when the MSBs differ and the low bits are equal; both are registered-pointer functions.
REQ-015 SHALL arbitrate round-robin between the requesters: a lone valid wins; if both are valid, the requester not granted last wins.
REQ-016 SHALL assert reqN_ready = grantN & !full combinationally; a write is accepted on reqN_valid & reqN_ready.
REQ-017 SHALL drive ram_wen = accept, ram_waddr = wptr[ADDR_W-1:0] and ram_wdata = the granted requester's data in the same cycle, then increment wptr.
REQ-018 SHALL update the last-grant state only on an accepted write.
REQ-019 SHALL assert ram_ren = pop & !empty and ram_raddr = rptr[ADDR_W-1:0] in the same cycle, then increment rptr.
REQ-020 SHALL register rdata_valid one cycle after ram_ren (read latency 1).
REQ-021 SHALL ignore pop while empty, with no ram_ren and no pointer change.
REQ-022 SHALL deassert both readies while full, even when pop is asserted in the same cycle; no write-through-when-full.
REQ-023 SHALL accept a simultaneous write and pop when neither flag blocks them; occupancy is then unchanged.
REQ-024 SHALL treat the RAM's same-address write/read collision as impossible, since reads occur only when not empty.

Reset
REQ-025 SHALL, on rst_n low, immediately force wptr=0, rptr=0, rdata_valid=0 and last-grant=requester 1, so requester 0 wins first.
REQ-026 SHALL, while in reset, drive empty=1, full=0, ram_wen=0, ram_ren=0 and both readies 0.
REQ-027 SHALL discard all contents on reset mid-operation, with no stale rdata_valid afterwards; the RAM is not cleared.

Configuration
REQ-028 SHALL, when RAM_FIFO_CTRL_LEVEL_EN is defined, add output level[ADDR_W:0] = wptr - rptr (modulo 2**(ADDR_W+1)), range 0..8.
REQ-029 SHALL, when RAM_FIFO_CTRL_LEVEL_EN is undefined, omit the level port and its subtractor; all other behaviour is identical.

Structure
REQ-030 SHALL place ADDR_W/DATA_W defaults, DEPTH and the grant encoding (GNT_REQ0, GNT_REQ1) in shared package ram_fifo_pkg.
REQ-031 SHALL implement arbitration in sub-module rr_arb2 (inputs: valid pair, last-grant state, advance enable; outputs: one-hot grant).

Verification
REQ-032 SHALL cover: after reset, req0_valid=1 with data 3'h5 -> ram_wen=1, waddr=0, wdata=5; next cycle empty=0.
REQ-033 SHALL cover: both valid for 4 cycles with req0=1, req1=2 -> grants alternate 0,1,0,1 and waddr=0..3.
REQ-034 SHALL cover: 8 writes with no pop -> full=1; a 9th write sees ready=0; a pop plus write in the same cycle -> write is still refused.
REQ-035 SHALL cover: pop on empty -> ram_ren=0, rptr unchanged, rdata_valid=0 the next cycle.
REQ-036 SHALL cover: 20 writes and reads interleaved -> pointers wrap, read data matches write order, and level (when enabled) never exceeds 8.
REQ-037 SHALL cover: rst_n pulsed low with 5 entries and a pop in flight -> empty=1, rdata_valid=0 the next cycle, and req0 wins first after reset.

Source files
------------

// File: rtl/ram_fifo_pkg.sv
// Shared sizing defaults and grant encoding for the RAM-backed FIFO controller.
package ram_fifo_pkg;

  localparam int ADDR_W_DEF = 32'sd3;
  localparam int DATA_W_DEF = 32'sd3;
  localparam int DEPTH      = 32'sd1 << ADDR_W_DEF;

  typedef enum logic {
    GNT_REQ0 = 1'b0,
    GNT_REQ1 = 1'b1
  } gnt_e;

endpackage

// File: rtl/ram_fifo_ctrl_rr_arb2.sv
// Two-way round-robin arbiter; grant is one-hot and suppressed when not enabled.
module rr_arb2
  import ram_fifo_pkg::*;
(
  input  logic [1:0] valid,
  input  gnt_e       last_gnt,
  input  logic       adv_en,
  output logic [1:0] gnt
);

  // Under contention the requester that was not served last wins.
  always_comb begin
    gnt = 2'b00;
    if (!adv_en) begin
      gnt = 2'b00;
    end else begin
      case (valid)
        2'b01:   gnt = 2'b01;
        2'b10:   gnt = 2'b10;
        2'b11:   gnt = (last_gnt == GNT_REQ0) ? 2'b10 : 2'b01;
        default: gnt = 2'b00;
      endcase
    end
  end

endmodule

// File: rtl/ram_fifo_ctrl.sv
// FIFO controller in front of a 1-cycle-latency dual-port RAM, two arbitrated writers.
// Optional occupancy output enabled by defining RAM_FIFO_CTRL_LEVEL_EN.
module ram_fifo_ctrl
  import ram_fifo_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  input  logic              pop,
  output logic              rdata_valid,
  output logic              full,
  output logic              empty,
  output logic              ram_wen,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic              ram_ren,
  output logic [ADDR_W-1:0] ram_raddr
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  ,
  output logic [ADDR_W:0]   level
`endif
);

  localparam logic [ADDR_W:0] PTR_INC = {{ADDR_W{1'b0}}, 1'b1};

  logic [ADDR_W:0] wptr_r;
  logic [ADDR_W:0] rptr_r;
  logic            rdata_valid_r;
  gnt_e            last_gnt_r;
  logic            full_s;
  logic            empty_s;
  logic            arb_en_s;
  logic            wr_en_s;
  logic            rd_en_s;
  logic [1:0]      gnt_s;

  assign empty_s  = (wptr_r == rptr_r);
  assign full_s   = (wptr_r[ADDR_W] != rptr_r[ADDR_W]) &&
                    (wptr_r[ADDR_W-1:0] == rptr_r[ADDR_W-1:0]);
  // Gating with rst_n keeps the write side quiet while reset is held.
  assign arb_en_s = rst_n & ~full_s;

  rr_arb2 u_arb (
    .valid    ({req1_valid, req0_valid}),
    .last_gnt (last_gnt_r),
    .adv_en   (arb_en_s),
    .gnt      (gnt_s)
  );

  assign wr_en_s = (req0_valid & gnt_s[0]) | (req1_valid & gnt_s[1]);
  assign rd_en_s = rst_n & pop & ~empty_s;

  // Write-data mux selects the granted requester.
  always_comb begin
    ram_wdata = req0_data;
    if (gnt_s[1]) begin
      ram_wdata = req1_data;
    end else begin
      ram_wdata = req0_data;
    end
  end

  // Pointer, last-grant and read-valid state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_r        <= {(ADDR_W+1){1'b0}};
      rptr_r        <= {(ADDR_W+1){1'b0}};
      rdata_valid_r <= 1'b0;
      last_gnt_r    <= GNT_REQ1;
    end else begin
      if (wr_en_s) begin
        wptr_r     <= wptr_r + PTR_INC;
        last_gnt_r <= gnt_s[1] ? GNT_REQ1 : GNT_REQ0;
      end
      if (rd_en_s) begin
        rptr_r <= rptr_r + PTR_INC;
      end
      rdata_valid_r <= rd_en_s;
    end
  end

  assign req0_ready  = gnt_s[0];
  assign req1_ready  = gnt_s[1];
  assign full        = full_s;
  assign empty       = empty_s;
  assign ram_wen     = wr_en_s;
  assign ram_waddr   = wptr_r[ADDR_W-1:0];
  assign ram_ren     = rd_en_s;
  assign ram_raddr   = rptr_r[ADDR_W-1:0];
  assign rdata_valid = rdata_valid_r;

`ifdef RAM_FIFO_CTRL_LEVEL_EN
  assign level = wptr_r - rptr_r;
`endif

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Self-checking bench for ram_fifo_ctrl: directed vector table, corner sequences
// and random traffic against a queue-based FIFO model with a behavioural RAM.
module tb_ram_fifo_ctrl;

  localparam int AW = 3;
  localparam int DW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid, pop;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready, rdata_valid, full, empty;
  logic          ram_wen, ram_ren;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata;
`ifdef RAM_FIFO_CTRL_LEVEL_EN
  logic [AW:0]   level;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  ram_fifo_ctrl #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .pop        (pop),
    .rdata_valid(rdata_valid),
    .full       (full),
    .empty      (empty),
    .ram_wen    (ram_wen),
    .ram_waddr  (ram_waddr),
    .ram_wdata  (ram_wdata),
    .ram_ren    (ram_ren),
    .ram_raddr  (ram_raddr)
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    ,
    .level      (level)
`endif
  );

  always #5 clk = ~clk;

  // Behavioural 8-entry RAM with one-cycle read latency.
  logic [DW-1:0] mem [8];
  logic [DW-1:0] rdata;
  always @(posedge clk) begin
    if (ram_wen) mem[ram_waddr] <= ram_wdata;
    if (ram_ren) rdata <= mem[ram_raddr];
  end

  // FIFO reference model.
  logic [DW-1:0] m_q[$];
  int            m_wcnt, m_rcnt, m_last;
  logic          m_prev_ren;
  logic [DW-1:0] m_prev_data;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_q.delete();
    m_wcnt = 0;
    m_rcnt = 0;
    m_last = 1;
    m_prev_ren = 1'b0;
    m_prev_data = '0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1; pop = 1'b1;
    req0_data = 3'd1;  req1_data = 3'd2;
    #2;
    chk("rst_ready0", req0_ready, 0);
    chk("rst_ready1", req1_ready, 0);
    chk("rst_wen", ram_wen, 0);
    chk("rst_ren", ram_ren, 0);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_rdata_valid", rdata_valid, 0);
    @(posedge clk); #1;
    req0_valid = 1'b0; req1_valid = 1'b0; pop = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
  endtask

  // One clock of traffic checked against the model; returns at posedge+1.
  task automatic cycle(input logic v0, input logic v1, input logic [DW-1:0] d0,
                       input logic [DW-1:0] d1, input logic p);
    int g;
    logic full_m, empty_m, r0, r1, wen, ren;
    logic [DW-1:0] wd;
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; pop = p;
    @(negedge clk);
    full_m  = (m_q.size() == 8);
    empty_m = (m_q.size() == 0);
    if (v0 && v1)  g = (m_last == 0) ? 1 : 0;
    else if (v0)   g = 0;
    else if (v1)   g = 1;
    else           g = -1;
    r0  = (g == 0) && !full_m;
    r1  = (g == 1) && !full_m;
    wen = r0 || r1;
    wd  = (g == 1) ? d1 : d0;
    ren = p && !empty_m;
    chk("empty", empty, empty_m);
    chk("full", full, full_m);
    chk("ready0", req0_ready, r0);
    chk("ready1", req1_ready, r1);
    chk("ram_wen", ram_wen, wen);
    chk("ram_waddr", ram_waddr, m_wcnt % 8);
    if (wen) chk("ram_wdata", ram_wdata, wd);
    chk("ram_ren", ram_ren, ren);
    chk("ram_raddr", ram_raddr, m_rcnt % 8);
    chk("rdata_valid", rdata_valid, m_prev_ren);
    if (m_prev_ren) chk("rdata", rdata, m_prev_data);
`ifdef RAM_FIFO_CTRL_LEVEL_EN
    chk("level", level, m_q.size());
    chk("level_le_8", level <= 8, 1);
`endif
    @(posedge clk); #1;
    m_prev_ren = ren;
    if (ren) begin
      m_prev_data = m_q.pop_front();
      m_rcnt++;
    end
    if (wen) begin
      m_q.push_back(wd);
      m_last = g;
      m_wcnt++;
    end
  endtask

  typedef struct {
    logic          rst;
    logic          v0, v1;
    logic [DW-1:0] d0, d1;
    logic          p;
    logic          e_rdy0, e_rdy1, e_wen;
    logic [AW-1:0] e_waddr;
    logic [DW-1:0] e_wdata;
    logic          e_ren;
    logic [AW-1:0] e_raddr;
    logic          e_empty, e_full, e_rv;
    logic [DW-1:0] e_rdata;
  } vec_t;

  vec_t vecs[11];

  initial begin
    rst_n = 1'b0;
    req0_valid = 1'b0; req1_valid = 1'b0; pop = 1'b0;
    req0_data = '0; req1_data = '0;
    model_reset();

    //         rst  v0    v1    d0    d1    p     rdy0  rdy1  wen   waddr wdata ren   raddr empty full  rv    rdata
    vecs[0]  = '{1'b1,1'b1,1'b1,3'd1,3'd2,1'b0,1'b1,1'b0,1'b1,3'd0,3'd1,1'b0,3'd0,1'b1,1'b0,1'b0,3'd0};
    vecs[1]  = '{1'b0,1'b1,1'b1,3'd1,3'd2,1'b0,1'b0,1'b1,1'b1,3'd1,3'd2,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[2]  = '{1'b0,1'b1,1'b1,3'd1,3'd2,1'b0,1'b1,1'b0,1'b1,3'd2,3'd1,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[3]  = '{1'b0,1'b1,1'b1,3'd1,3'd2,1'b0,1'b0,1'b1,1'b1,3'd3,3'd2,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[4]  = '{1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,3'd4,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[5]  = '{1'b1,1'b1,1'b0,3'd5,3'd0,1'b0,1'b1,1'b0,1'b1,3'd0,3'd5,1'b0,3'd0,1'b1,1'b0,1'b0,3'd0};
    vecs[6]  = '{1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,3'd1,3'd0,1'b0,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[7]  = '{1'b1,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,3'd0,1'b1,1'b0,1'b0,3'd0};
    vecs[8]  = '{1'b0,1'b1,1'b0,3'd7,3'd0,1'b1,1'b1,1'b0,1'b1,3'd0,3'd7,1'b0,3'd0,1'b1,1'b0,1'b0,3'd0};
    vecs[9]  = '{1'b0,1'b0,1'b0,3'd0,3'd0,1'b1,1'b0,1'b0,1'b0,3'd1,3'd0,1'b1,3'd0,1'b0,1'b0,1'b0,3'd0};
    vecs[10] = '{1'b0,1'b0,1'b0,3'd0,3'd0,1'b0,1'b0,1'b0,1'b0,3'd1,3'd0,1'b0,3'd1,1'b1,1'b0,1'b1,3'd7};

    for (int i = 0; i < 11; i++) begin
      if (vecs[i].rst) do_reset();
      req0_valid = vecs[i].v0; req1_valid = vecs[i].v1;
      req0_data  = vecs[i].d0; req1_data  = vecs[i].d1;
      pop        = vecs[i].p;
      @(negedge clk);
      chk($sformatf("vec%0d_ready0", i), req0_ready, vecs[i].e_rdy0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, vecs[i].e_rdy1);
      chk($sformatf("vec%0d_wen", i), ram_wen, vecs[i].e_wen);
      chk($sformatf("vec%0d_waddr", i), ram_waddr, vecs[i].e_waddr);
      if (vecs[i].e_wen) chk($sformatf("vec%0d_wdata", i), ram_wdata, vecs[i].e_wdata);
      chk($sformatf("vec%0d_ren", i), ram_ren, vecs[i].e_ren);
      chk($sformatf("vec%0d_raddr", i), ram_raddr, vecs[i].e_raddr);
      chk($sformatf("vec%0d_empty", i), empty, vecs[i].e_empty);
      chk($sformatf("vec%0d_full", i), full, vecs[i].e_full);
      chk($sformatf("vec%0d_rdata_valid", i), rdata_valid, vecs[i].e_rv);
      if (vecs[i].e_rv) chk($sformatf("vec%0d_rdata", i), rdata, vecs[i].e_rdata);
      @(posedge clk); #1;
    end

    // Fill to full, then writes are refused even alongside a pop.
    do_reset();
    for (int i = 0; i < 8; i++) cycle(1'b1, 1'b0, DW'(i), 3'd0, 1'b0);
    chk("full_after_8", full, 1);
    cycle(1'b1, 1'b1, 3'd6, 3'd7, 1'b0);
    cycle(1'b1, 1'b0, 3'd6, 3'd0, 1'b1);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    chk("empty_after_drain", empty, 1);

    // Interleaved writes and reads wrapping both pointers.
    do_reset();
    for (int i = 0; i < 20; i++) cycle(1'b1, 1'b0, DW'(i), 3'd0, i >= 2);
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);

    // Reset with 5 entries and a pop in flight.
    do_reset();
    for (int i = 0; i < 5; i++) cycle(1'b0, 1'b1, 3'd0, DW'(i + 1), 1'b0);
    cycle(1'b0, 1'b0, 3'd0, 3'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("midrst_rdata_valid", rdata_valid, 0);
    chk("midrst_empty", empty, 1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    model_reset();
    cycle(1'b1, 1'b1, 3'd3, 3'd4, 1'b0);
    cycle(1'b1, 1'b1, 3'd3, 3'd4, 1'b1);

    // Random traffic against the model.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1,
            DW'($urandom_range(0, 7)), DW'($urandom_range(0, 7)),
            $urandom_range(0, 2) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
